ydriver_seq: RTL
================

Name: ydriver_seq

Overview:
- Vertical-timing sequencer that drives the row (Y) driver lanes of the DMG LCD.
- Generates the row-select start token `s`, the two-phase shift clocks `ck`/`cck` and the frame-polarity signal `fr` consumed by the lane chain.
- Tracks dot and line position so exactly one row lane is selected per active line, and the token is flushed out of the chain during vblank.
- Sits in the LCD controller, directly upstream of the lane chain.

Parameters:
- LINES, 144, active rows (number of lanes in the chain).
- VBLANK_LINES, 10, idle lines per frame after the active rows.
- DOTS, 456, clk cycles per line.
- CK_START, 8, dot index where the shift-clock pulse begins.
- CK_WIDTH, 4, shift-clock pulse length in dots.
- FR_PERIOD, 13, lines per half-period of `fr`.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- lcd_on  in  1  display enable; low = sequencer idle.
- s  out  1  start token to the first lane's mux `i0` input.
- ck  out  1  lane mux shift clock, true phase.
- cck  out  1  lane mux shift clock, complement phase.
- fr  out  1  frame-inversion polarity to all lanes.
- ly  out  8  current line index 0..LINES+VBLANK_LINES-1.
- vblank  out  1  high while ly >= LINES.
- frame_start  out  1  one-cycle pulse at line 0, dot 0.

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset values: s=0, ck=0, cck=1, fr=0, ly=0, vblank=0, frame_start=0.
- Reset also clears the internal dot counter, line counter and fr counter.
- Reset has priority over `lcd_on` and applies mid-frame identically.

Counters:
- dot: 0..DOTS-1.
- line: 0..LINES+VBLANK_LINES-1.
- dot increments every cycle while `lcd_on`=1. At DOTS-1 it wraps to 0 and `line` increments.
- At the last line plus last dot, `line` wraps to 0 (new frame).
- The first cycle `lcd_on` is sampled high is line 0, dot 0.
- While `lcd_on`=0, both counters are held at 0.

Outputs:
- All outputs are registered decodes of the counters. Latency is exactly 1 cycle: outputs at edge t+1 reflect counter state during cycle t.
- s = 1 for every dot of line 0, otherwise 0.
- ck = 1 when CK_START <= dot < CK_START+CK_WIDTH and line <= LINES.
  - This gives LINES+1 pulses per frame; the extra pulse on line LINES shifts the token out of the last lane.
  - ck stays 0 on lines LINES+1 onward.
- cck = ~ck at all times. Both are taken from the same register stage, so there is no skew.
- frame_start = 1 when line=0 and dot=0.
- ly = line. vblank = (line >= LINES).

fr:
- A free-running fr counter (0..FR_PERIOD-1) advances at each dot-0 cycle.
- On wrap, `fr` toggles on the following edge.
- The fr counter is not cleared at frame start, so polarity drifts across frames (intended DC balancing).

lcd_on transitions:
- Falling edge (sampled 0), including mid-line: on the next edge, counters go to 0, s=0, ck=0, cck=1, frame_start=0, ly=0, vblank=0.
- Falling edge: fr is forced to 0 and the fr counter is cleared.
- Rising edge: the sequence restarts at line 0, dot 0. A partial frame is never resumed.

Boundaries:
- Width: ly is 8 bits; LINES+VBLANK_LINES <= 256 is required.
- Parameter constraint: CK_START+CK_WIDTH <= DOTS.
- Parameter constraint: CK_START >= 1, so `s` is stable at least one cycle before `ck` rises.

Test Plan:
- Reset, then lcd_on=1 at cycle 0 → cycle 1: s=1, frame_start=1, ly=0, ck=0. Cycles 9..12: ck=1, cck=0. Cycle 13: ck=0. Cycle 457: s=0, ly=1.
- Run one full frame (154×456 cycles) → count exactly 145 ck pulses.
  - Last pulse occurs on ly=144 with vblank=1.
  - No ck on ly=145..153.
  - frame_start pulses again at cycle 70225.
  - ck and cck are never equal.
- fr check → fr toggles at dot 0 of lines 13, 26, 39, ...; first toggle at cycle 13×456+1. Across the frame wrap (154 lines), toggles continue on the free-running count, e.g. next after line 143 is at frame 2, line 2.
- Drop lcd_on at line 50, dot 10 (ck idle) → next edge: all outputs at reset values. Re-raise after 100 cycles → restart with s=1, ly=0, frame_start=1 one cycle later.
- Assert reset during a ck pulse (line 3, dot 10) → next edge: ck=0, cck=1, fr=0, ly=0. With lcd_on still 1, the counter restarts at line 0, dot 0 on the cycle after reset deasserts.
- Drive a 144-lane behavioural chain model → exactly one lane holds the token on each active line. The token matches ly. The chain is empty from ly=145 to the end of the frame.

Source files
------------

// File: rtl/ydriver_seq.sv
// Vertical-timing sequencer for the LCD row-driver lane chain: start token,
// two-phase shift clock, frame polarity and line position, all registered.
module ydriver_seq #(
  parameter int LINES        = 144,
  parameter int VBLANK_LINES = 10,
  parameter int DOTS         = 456,
  parameter int CK_START     = 8,
  parameter int CK_WIDTH     = 4,
  parameter int FR_PERIOD    = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_on,
  output logic       s,
  output logic       ck,
  output logic       cck,
  output logic       fr,
  output logic [7:0] ly,
  output logic       vblank,
  output logic       frame_start
);

  localparam int DW = $clog2(DOTS + 1);
  localparam int FW = $clog2(FR_PERIOD + 1);

  localparam logic [DW-1:0] DOT_LAST  = DW'(DOTS - 1);
  localparam logic [DW-1:0] CK_LO     = DW'(CK_START);
  localparam logic [DW-1:0] CK_HI     = DW'(CK_START + CK_WIDTH);
  localparam logic [7:0]    LINE_LAST = 8'(LINES + VBLANK_LINES - 1);
  localparam logic [7:0]    LINES_C   = 8'(LINES);
  localparam logic [FW-1:0] FR_LAST   = FW'(FR_PERIOD - 1);

  logic [DW-1:0] dot;
  logic [7:0]    line;
  logic [FW-1:0] fr_cnt;
  logic          fr_tgl;
  logic          ck_win;
  logic          dot_last;

  assign ck_win   = (dot >= CK_LO) && (dot < CK_HI) && (line <= LINES_C);
  assign dot_last = (dot == DOT_LAST);

  always_ff @(posedge clk) begin
    if (reset || !lcd_on) begin
      dot         <= '0;
      line        <= '0;
      fr_cnt      <= '0;
      fr_tgl      <= 1'b0;
      s           <= 1'b0;
      ck          <= 1'b0;
      cck         <= 1'b1;
      fr          <= 1'b0;
      ly          <= '0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (dot_last) begin
        dot  <= '0;
        line <= (line == LINE_LAST) ? 8'd0 : line + 8'd1;
      end else begin
        dot <= dot + DW'(1);
      end

      // fr_cnt counts completed lines free-running across frames; the toggle
      // is armed at the end of the wrapping line and lands on the next dot 0.
      if (dot_last) begin
        fr_cnt <= (fr_cnt == FR_LAST) ? '0 : fr_cnt + FW'(1);
      end
      fr_tgl <= dot_last && (fr_cnt == FR_LAST);
      if (fr_tgl) begin
        fr <= ~fr;
      end

      s           <= (line == 8'd0);
      ck          <= ck_win;
      cck         <= ~ck_win;
      ly          <= line;
      vblank      <= (line >= LINES_C);
      frame_start <= (line == 8'd0) && (dot == '0);
    end
  end

endmodule
